// File: rtl/boot_loader_if.sv
// Boot loader bus bundle: source (boot ROM/flash) read handshake and main-memory write port.
// The master side is the boot loader; the slave side is the ROM/memory subsystem.
interface boot_loader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SRC_AW = 11
);
    logic              src_req;
    logic [SRC_AW-1:0] src_idx;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wready;

    modport master (
        output src_req, src_idx, mem_wen, mem_waddr, mem_wdata,
        input  src_valid, src_data, mem_wready
    );

    modport slave (
        input  src_req, src_idx, mem_wen, mem_waddr, mem_wdata,
        output src_valid, src_data, mem_wready
    );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: holds the core in reset, copies IMG_WORDS words from boot ROM into memory at BOOT_BASE.
// Optional BOOT_CHECKSUM_EN: compare the sum of copied words against the word at source index IMG_WORDS.
module boot_loader #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BOOT_BASE = ADDR_W'(32'h8000_0000),
    parameter int unsigned       IMG_WORDS = 1024,
    parameter int unsigned       SRC_AW    = 11,
    parameter int unsigned       RST_HOLD  = 4
) (
    input  logic          clk,
    input  logic          global_rst,
    output logic          init_rst,
    output logic          boot_done,
    output logic          boot_err,
    boot_loader_if.master bus
);

    localparam logic [SRC_AW-1:0] LAST_IDX  = SRC_AW'(IMG_WORDS - 1);
    localparam logic [7:0]        HOLD_LAST = 8'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        S_HOLD  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
`ifdef BOOT_CHECKSUM_EN
        ,
        S_CHECK = 3'd6
`endif
    } state_t;

    state_t            state;
    logic [7:0]        hold_cnt;
    logic [SRC_AW-1:0] idx;
    logic              src_req_q;
    logic              mem_wen_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic              err_q;
`endif

    // Sequencer: src_req is a one-cycle strobe raised on entry to READ (or CHECK)
    always_ff @(posedge clk) begin
        if (global_rst) begin
            state     <= S_HOLD;
            hold_cnt  <= 8'd0;
            idx       <= '0;
            src_req_q <= 1'b0;
            mem_wen_q <= 1'b0;
            init_rst  <= 1'b1;
            boot_done <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum       <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            src_req_q <= 1'b0;
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= S_READ;
                        idx       <= '0;
                        src_req_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                S_READ: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.src_valid) begin
                        wdata_q   <= bus.src_data;
                        waddr_q   <= BOOT_BASE + (ADDR_W'(idx) << 2);
                        mem_wen_q <= 1'b1;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.mem_wready) begin
                        mem_wen_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                        sum <= sum + wdata_q;
`endif
                        if (idx == LAST_IDX) begin
`ifdef BOOT_CHECKSUM_EN
                            state     <= S_CHECK;
                            idx       <= SRC_AW'(IMG_WORDS);
                            src_req_q <= 1'b1;
`else
                            state     <= S_DONE;
                            init_rst  <= 1'b0;
                            boot_done <= 1'b1;
`endif
                        end else begin
                            idx       <= idx + SRC_AW'(1);
                            state     <= S_READ;
                            src_req_q <= 1'b1;
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                // First CHECK cycle carries the strobe; the response can only arrive afterwards
                S_CHECK: begin
                    if (!src_req_q && bus.src_valid) begin
                        if (bus.src_data == sum) begin
                            state     <= S_DONE;
                            init_rst  <= 1'b0;
                            boot_done <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERR: state <= state;
                default: state <= S_HOLD;
            endcase
        end
    end

`ifdef BOOT_CHECKSUM_EN
    assign boot_err = err_q;
`else
    assign boot_err = 1'b0;
`endif

    assign bus.src_req   = src_req_q;
    assign bus.src_idx   = idx;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;

endmodule
